// File: rtl/syn_fb_pxl_wr.sv
// Frame-buffer pixel writer: packs 8b pixel writes into 16b SRAM
// word writes with byte enables, merging even/odd pairs when possible.
module syn_fb_pxl_wr #(
  parameter int unsigned P_WIDTH   = 640,
  parameter int unsigned P_HEIGHT  = 480,
  parameter int unsigned P_FB_BASE = 0
) (
  input  logic        clk_ir,
  input  logic        rst_sync_l,
  input  logic        pxl_valid,
  output logic        pxl_ready,
  input  logic [9:0]  pxl_x,
  input  logic [8:0]  pxl_y,
  input  logic [7:0]  pxl_data,
  output logic        sram_req,
  input  logic        sram_gnt,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic [1:0]  sram_be,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_REQ
  } state_t;

  state_t      r_state;
  state_t      w_nstate;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic [15:0] r_drop;

  logic        w_in_range;
  logic [17:0] w_waddr;
  logic [1:0]  w_lane_be;
  logic [15:0] w_lane_data;
  logic        w_ready;
  logic        w_acc;

  assign w_in_range =
    (32'(pxl_x) < P_WIDTH) &&
    (32'(pxl_y) < P_HEIGHT);

  assign w_waddr = 18'(
    P_FB_BASE +
    32'(pxl_y) * (P_WIDTH / 2) +
    32'(pxl_x[9:1]));

  assign w_lane_be = pxl_x[0] ? 2'b10 : 2'b01;

  assign w_lane_data = pxl_x[0] ?
    {pxl_data, 8'h00} :
    {8'h00, pxl_data};

  always_comb begin
    w_nstate = r_state;
    w_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (pxl_valid && w_in_range)
          w_nstate = S_PEND;
      end
      S_PEND: begin
        // merge only the other lane of the same word
        w_ready = w_in_range &&
          (w_waddr == r_addr) &&
          ((w_lane_be & r_be) == 2'b00);
        w_nstate = S_REQ;
      end
      S_REQ: begin
        if (sram_gnt)
          w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign pxl_ready = w_ready && rst_sync_l;
  assign w_acc     = pxl_valid && pxl_ready;

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_acc && w_in_range) begin
        if (r_state == S_IDLE) begin
          r_addr  <= w_waddr;
          r_wdata <= w_lane_data;
          r_be    <= w_lane_be;
        end else begin
          r_wdata <= r_wdata | w_lane_data;
          r_be    <= r_be | w_lane_be;
        end
      end
      if (w_acc && !w_in_range &&
          r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
    end
  end

  assign sram_req   = (r_state == S_REQ);
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_be    = r_be;
  assign drop_cnt   = r_drop;

endmodule
